// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot loader control block.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_MAGIC,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LENGTH  = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    localparam logic [7:0] MAGIC = 8'hB5;

    // A zero-length image or one larger than the payload buffer is rejected.
    function automatic logic len_ok(input logic [15:0] len, input int unsigned max_len);
        return (len != 16'd0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/uart_loader_ctrl_cnt.sv
// Payload byte-index counter: synchronous clear, increment by one.
module uart_loader_ctrl_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/uart_loader_ctrl.sv
// UART boot image loader: magic byte, 16-bit LE length, payload written to memory.
// Define LOADER_CSUM_EN to require a trailing 8-bit modulo-sum checksum byte.
module uart_loader_ctrl
    import loader_pkg::*;
#(
    parameter int NUM_BYTES = 256,
    parameter int ADDR_W    = $clog2(NUM_BYTES)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              timeout,
    input  logic              err_clr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              boot_go,
    output logic [1:0]        err_code
);

    // state         | meaning
    // WAIT_MAGIC    | idle, scanning for the magic byte
    // LEN_LO/LEN_HI | collecting the little-endian length
    // PAYLOAD       | writing payload bytes to memory
    // CHECK         | comparing the checksum byte (checksum build only)
    // DONE          | image accepted, held until reset
    // ERROR         | image rejected, held until err_clr

    state_t            state;
    err_t              err_q;
    logic [7:0]        len_lo;
    logic [15:0]       length;
    logic [15:0]       len_new;
    logic [ADDR_W-1:0] idx;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              last_byte;
`ifdef LOADER_CSUM_EN
    logic [7:0]        sum;
`endif

    assign len_new   = {byte_data, len_lo};
    assign cnt_clr   = (state == ST_LEN_HI) && byte_valid && !timeout;
    assign cnt_inc   = (state == ST_PAYLOAD) && byte_valid && !timeout;
    assign last_byte = (32'(idx) + 32'd1) == 32'(length);
    assign err_code  = err_q;

    uart_loader_ctrl_cnt #(.W(ADDR_W)) u_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (idx)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_WAIT_MAGIC;
            err_q     <= ERR_NONE;
            len_lo    <= 8'd0;
            length    <= 16'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            busy      <= 1'b0;
            boot_go   <= 1'b0;
`ifdef LOADER_CSUM_EN
            sum       <= 8'd0;
`endif
        end else begin
            mem_we  <= 1'b0;
            boot_go <= 1'b0;
            case (state)
                ST_WAIT_MAGIC: begin
                    if (byte_valid && byte_data == MAGIC) begin
                        state <= ST_LEN_LO;
                        busy  <= 1'b1;
                    end
                end
                ST_LEN_LO: begin
                    if (timeout) begin
                        state <= ST_ERROR;
                        err_q <= ERR_TIMEOUT;
                        busy  <= 1'b0;
                    end else if (byte_valid) begin
                        len_lo <= byte_data;
                        state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (timeout) begin
                        state <= ST_ERROR;
                        err_q <= ERR_TIMEOUT;
                        busy  <= 1'b0;
                    end else if (byte_valid) begin
                        length <= len_new;
                        if (len_ok(len_new, NUM_BYTES)) begin
                            state <= ST_PAYLOAD;
`ifdef LOADER_CSUM_EN
                            sum   <= 8'd0;
`endif
                        end else begin
                            state <= ST_ERROR;
                            err_q <= ERR_LENGTH;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (timeout) begin
                        state <= ST_ERROR;
                        err_q <= ERR_TIMEOUT;
                        busy  <= 1'b0;
                    end else if (byte_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= idx;
                        mem_wdata <= byte_data;
`ifdef LOADER_CSUM_EN
                        sum       <= sum + byte_data;
                        if (last_byte) begin
                            state <= ST_CHECK;
                        end
`else
                        if (last_byte) begin
                            state   <= ST_DONE;
                            busy    <= 1'b0;
                            boot_go <= 1'b1;
                        end
`endif
                    end
                end
`ifdef LOADER_CSUM_EN
                ST_CHECK: begin
                    if (timeout) begin
                        state <= ST_ERROR;
                        err_q <= ERR_TIMEOUT;
                        busy  <= 1'b0;
                    end else if (byte_valid) begin
                        busy <= 1'b0;
                        if (byte_data == sum) begin
                            state   <= ST_DONE;
                            boot_go <= 1'b1;
                        end else begin
                            state <= ST_ERROR;
                            err_q <= ERR_CSUM;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    state <= ST_DONE;
                end
                ST_ERROR: begin
                    if (err_clr) begin
                        state <= ST_WAIT_MAGIC;
                        err_q <= ERR_NONE;
                    end
                end
                default: begin
                    state <= ST_WAIT_MAGIC;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Randomized frame-level bench for uart_loader_ctrl with a frame-outcome reference model.
module tb_uart_loader_ctrl;

    localparam int NB = 256;
    localparam int AW = 8;
`ifdef LOADER_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'd0;
    logic          timeout = 1'b0;
    logic          err_clr = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          boot_go;
    logic [1:0]    err_code;

    int checks = 0;
    int failures = 0;

    logic [7:0] junk[$];
    logic [7:0] pl[$];
    int         wq_addr[$];
    int         wq_data[$];
    int         boot_cycles = 0;

    uart_loader_ctrl #(.NUM_BYTES(NB)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .timeout    (timeout),
        .err_clr    (err_clr),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .boot_go    (boot_go),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (n_rst) begin
            if (mem_we) begin
                wq_addr.push_back(int'(mem_addr));
                wq_data.push_back(int'(mem_wdata));
            end
            if (boot_go) boot_cycles <= boot_cycles + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit to, input int gap);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        timeout    = to;
        @(negedge clk);
        byte_valid = 1'b0;
        timeout    = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_to();
        @(negedge clk);
        timeout = 1'b1;
        @(negedge clk);
        timeout = 1'b0;
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        boot_cycles = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        byte_valid = 1'b0;
        timeout = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        clear_mon();
    endtask

    task automatic check_writes(input string tag, input int n);
        chk({tag, "_nwr"}, wq_addr.size(), n);
        for (int i = 0; i < n && i < wq_addr.size(); i++) begin
            chk({tag, "_addr"}, wq_addr[i], i);
            chk({tag, "_data"}, wq_data[i], 32'(pl[i]));
        end
    endtask

    // Minimal 1-byte image, used to prove whether the loader is back in its idle state.
    task automatic mini_frame(input logic [7:0] v);
        send(8'hB5, 1'b0, 0);
        send(8'h01, 1'b0, 0);
        send(8'h00, 1'b0, 0);
        send(v, 1'b0, 1);
        if (CS == 1) send(v, 1'b0, 1);
        repeat (2) @(negedge clk);
    endtask

    // Outcome of a frame is derived from where (if anywhere) the timeout lands,
    // whether the length is legal, and whether the checksum byte is right.
    task automatic run_frame(input int len, input bit bad, input int tpos, input bit to_same);
        logic [7:0]  st[$];
        logic [7:0]  sum;
        logic [7:0]  v;
        logic [15:0] l16;
        bit          valid;
        int          n_stream, exp_err, exp_nw, exp_boot;
        l16   = 16'(len);
        valid = (len > 0) && (len <= NB);
        sum   = 8'd0;
        do_reset();
        foreach (junk[i]) send(junk[i], $urandom_range(0, 3) == 0, $urandom_range(0, 2));
        send(8'hB5, 1'b0, 0);
        chk("busy_after_magic", 32'(busy), 1);
        st.push_back(l16[7:0]);
        st.push_back(l16[15:8]);
        if (valid) begin
            for (int i = 0; i < len; i++) begin
                st.push_back(pl[i]);
                sum = sum + pl[i];
            end
            if (CS == 1) st.push_back(bad ? (sum ^ 8'h07) : sum);
        end
        n_stream = st.size();
        for (int i = 0; i < n_stream; i++) begin
            if (i == tpos && !to_same) pulse_to();
            send(st[i], (i == tpos) && to_same, $urandom_range(0, 2));
        end
        if (tpos == n_stream) pulse_to();
        repeat (2) @(negedge clk);
        send(8'hB5, 1'b0, 0);
        send(8'h01, 1'b0, 0);
        send(8'(($urandom)), 1'b0, 2);

        if (tpos >= 0 && tpos < n_stream) begin
            exp_err  = 3;
            exp_nw   = (tpos > 2) ? tpos - 2 : 0;
            exp_boot = 0;
        end else if (!valid) begin
            exp_err = 1; exp_nw = 0; exp_boot = 0;
        end else if (CS == 1 && bad) begin
            exp_err = 2; exp_nw = len; exp_boot = 0;
        end else begin
            exp_err = 0; exp_nw = len; exp_boot = 1;
        end

        check_writes("frame", exp_nw);
        chk("boot_cycles", boot_cycles, exp_boot);
        chk("err_code", 32'(err_code), exp_err);
        chk("busy_end", 32'(busy), 0);

        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_after_clr", 32'(err_code), 0);

        clear_mon();
        v = 8'($urandom);
        mini_frame(v);
        if (exp_err != 0) begin
            chk("post_nwr", wq_addr.size(), 1);
            if (wq_addr.size() == 1) chk("post_data", wq_data[0], 32'(v));
            chk("post_boot", boot_cycles, 1);
        end else begin
            chk("held_nwr", wq_addr.size(), 0);
            chk("held_boot", boot_cycles, 0);
        end
    endtask

    initial begin
        int len, n_stream, tpos;
        logic [7:0] b;
        #12;
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_boot_go", 32'(boot_go), 0);
        chk("rst_err_code", 32'(err_code), 0);

        junk = {};
        pl = {8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(4, 1'b0, -1, 1'b0);

        junk = {8'h00, 8'h7F};
        pl = {8'h5A};
        run_frame(1, 1'b0, -1, 1'b0);

        junk = {};
        pl.delete();
        for (int i = 0; i < NB; i++) pl.push_back(8'($urandom));
        run_frame(NB, 1'b0, -1, 1'b0);
        run_frame(NB + 1, 1'b0, -1, 1'b0);
        run_frame(0, 1'b0, -1, 1'b0);

`ifdef LOADER_CSUM_EN
        pl = {8'h01, 8'h02};
        run_frame(2, 1'b1, -1, 1'b0);
`endif

        pl = {8'h01, 8'h02, 8'h03};
        run_frame(3, 1'b0, 3, 1'b0);
        run_frame(3, 1'b0, 4, 1'b1);

        // Asynchronous reset while a payload write strobe is active.
        do_reset();
        send(8'hB5, 1'b0, 0);
        send(8'h03, 1'b0, 0);
        send(8'h00, 1'b0, 0);
        send(8'h01, 1'b0, 0);
        chk("mid_we_before", 32'(mem_we), 1);
        #1 n_rst = 1'b0;
        #1;
        chk("mid_rst_mem_we", 32'(mem_we), 0);
        chk("mid_rst_mem_wdata", 32'(mem_wdata), 0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_boot_go", 32'(boot_go), 0);
        chk("mid_rst_err_code", 32'(err_code), 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        clear_mon();
        pl = {8'h5A};
        mini_frame(8'h5A);
        check_writes("after_rst", 1);
        chk("after_rst_boot", boot_cycles, 1);

        for (int it = 0; it < 30; it++) begin
            junk.delete();
            for (int j = 0; j < $urandom_range(0, 3); j++) begin
                b = 8'($urandom);
                if (b == 8'hB5) b = 8'h00;
                junk.push_back(b);
            end
            case ($urandom_range(0, 9))
                0:       len = 0;
                1:       len = $urandom_range(NB + 1, 65535);
                2:       len = NB;
                default: len = $urandom_range(1, 12);
            endcase
            pl.delete();
            for (int j = 0; j < len && j < NB; j++) pl.push_back(8'($urandom));
            n_stream = 2 + (((len > 0) && (len <= NB)) ? len + CS : 0);
            tpos = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n_stream) : -1;
            run_frame(len, $urandom_range(0, 2) == 0, tpos, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
